// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle multiplier among N_REQ requesters.
// Define MUL_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (err flag, forced zero result).
module mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 23,
  parameter int IDX_W   = $clog2(N_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   op1_bus,
  input  logic [N_REQ*WIDTH-1:0]   op2_bus,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [2*WIDTH-1:0]       res,
  output logic                     overflow,
  output logic                     err,
  output logic                     busy,
  output logic                     mul_en,
  output logic [WIDTH-1:0]         mul_op1,
  output logic [WIDTH-1:0]         mul_op2,
  input  logic [2*WIDTH-1:0]       mul_res,
  input  logic                     mul_val,
  input  logic                     mul_overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_paramCheck
    $error("mul_arbiter: N_REQ must be 2..8 and TIMEOUT at least 1");
  end

  logic [1:0]          r_state;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_done;
  logic [2*WIDTH-1:0]  r_res;
  logic                r_ovf;
  logic                r_busy;
  logic                r_mulEn;
  logic [WIDTH-1:0]    r_op1;
  logic [WIDTH-1:0]    r_op2;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_owner;

  logic                w_found;
  logic [IDX_W-1:0]    w_pick;
  logic [IDX_W-1:0]    w_cand;
  logic [N_REQ-1:0]    w_pickHot;
  logic [N_REQ-1:0]    w_ownerHot;
  logic [WIDTH-1:0]    w_op1;
  logic [WIDTH-1:0]    w_op2;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]     r_wdog;
  logic                r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Search upward from the slot after the last served requester, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_op1      = '0;
    w_op2      = '0;
    w_pickHot  = '0;
    w_ownerHot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_op1        = op1_bus[i*WIDTH +: WIDTH];
        w_op2        = op2_bus[i*WIDTH +: WIDTH];
        w_pickHot[i] = w_found;
      end
      if (r_owner == IDX_W'(i)) begin
        w_ownerHot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_mulEn <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_last  <= IDX_W'(N_REQ - 1);
      r_owner <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      r_wdog  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_gnt   <= '0;
      r_done  <= '0;
      r_mulEn <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_owner <= w_pick;
            r_gnt   <= w_pickHot;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mulEn <= 1'b1;
          r_state <= S_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        S_WAIT: begin
          if (mul_val) begin
            r_res   <= mul_res;
            r_ovf   <= mul_overflow;
            r_state <= S_RESP;
`ifdef MUL_ARB_TIMEOUT_EN
            r_err   <= 1'b0;
          end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
            // Give up on the multiplier; any later val lands outside WAIT.
            r_res   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_wdog  <= r_wdog + 1'b1;
`endif
          end
        end
        S_RESP: begin
          r_done  <= w_ownerHot;
          r_last  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign res      = r_res;
  assign overflow = r_ovf;
  assign busy     = r_busy;
  assign mul_en   = r_mulEn;
  assign mul_op1  = r_op1;
  assign mul_op2  = r_op2;

endmodule
